// File: rtl/sense_conditioner_pkg.sv
// Shared definitions for the sense conditioner: channel state encoding,
// default timing constants and saturating 8-bit counter helpers.
// Pure declarations; no logic of its own.
package sense_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QUAL  = 3'd1,
    ST_REFR  = 3'd2,
    ST_BLANK = 3'd3,
    ST_REARM = 3'd4
  } chan_state_t;

  localparam int DEF_DEB_N     = 4;
  localparam int DEF_BLANK_CYC = 16;
  localparam int DEF_REFR_A    = 32;
  localparam int DEF_REFR_V    = 64;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counters stick at full scale instead of wrapping to zero.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  // Counters stick at zero instead of wrapping to full scale.
  function automatic cnt_t sat_dec(input cnt_t v);
    return (v == '0) ? v : v - cnt_t'(1);
  endfunction

endpackage

// File: rtl/sense_channel.sv
// One sense channel: 2-flop synchronizer, debounce/refractory/blanking FSM.
// Latency: sense pulses 2+DEB_N-1 cycles after the first edge sampling raw high.
// Backpressure: none; sense/noise are single-cycle fire-and-forget pulses.
module sense_channel
  import sense_conditioner_pkg::*;
#(
  parameter int DEB_N     = DEF_DEB_N,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int REFR_LEN  = DEF_REFR_A
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic blank,
  output logic sense,
  output logic noise
);

  // All timing lengths live in 8-bit saturating counters.
  if (DEB_N < 1 || DEB_N > 255 || BLANK_CYC < 1 || BLANK_CYC > 255 ||
      REFR_LEN < 1 || REFR_LEN > 255) begin : g_param_check
    $error("sense_channel: DEB_N, BLANK_CYC and REFR_LEN must be in 1..255");
  end

  localparam cnt_t DEB_C   = cnt_t'(DEB_N);
  localparam cnt_t BLANK_C = cnt_t'(BLANK_CYC);
  localparam cnt_t REFR_C  = cnt_t'(REFR_LEN);

  logic [1:0]  sync_q, sync_d;
  // fill_q marks when the synchronizer holds real samples again after reset,
  // so the reset-cleared zeros are not mistaken for a genuine low input.
  logic [1:0]  fill_q, fill_d;
  chan_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        sense_q, sense_d;
  logic        noise_q, noise_d;
  logic        in_hi;

  assign in_hi = sync_q[1];
  assign sense = sense_q;
  assign noise = noise_q;

  // Next-state, counter and output pulse computation; a blanking pace wins over everything.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    fill_d  = {fill_q[0], 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    sense_d = 1'b0;
    noise_d = 1'b0;
    if (blank) begin
      state_d = ST_BLANK;
      cnt_d   = BLANK_C;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_hi) begin
            if (DEB_C == cnt_t'(1)) begin
              sense_d = 1'b1;
              state_d = ST_REFR;
              cnt_d   = REFR_C;
            end else begin
              state_d = ST_QUAL;
              cnt_d   = cnt_t'(1);
            end
          end
        end
        ST_QUAL: begin
          if (in_hi) begin
            if (sat_inc(cnt_q) >= DEB_C) begin
              sense_d = 1'b1;
              state_d = ST_REFR;
              cnt_d   = REFR_C;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            noise_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_REFR, ST_BLANK: begin
          if (cnt_q <= cnt_t'(1)) begin
            state_d = ST_REARM;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_dec(cnt_q);
          end
        end
        ST_REARM: begin
          if (fill_q[1] && !in_hi) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_REARM;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, synchronizer and registered output pulses; reset parks the channel in REARM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      state_q <= ST_REARM;
      cnt_q   <= '0;
      sense_q <= 1'b0;
      noise_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sense_q <= sense_d;
      noise_q <= noise_d;
    end
  end

endmodule

// File: rtl/sense_conditioner.sv
// Atrial/ventricular sense conditioner: two channels plus pace blanking routing.
// Latency: sa/sv pulse 2+DEB_N-1 cycles after the first edge sampling raw high.
// Backpressure: none; all outputs are single-cycle pulses.
module sense_conditioner
  import sense_conditioner_pkg::*;
#(
  parameter int DEB_N     = DEF_DEB_N,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int REFR_A    = DEF_REFR_A,
  parameter int REFR_V    = DEF_REFR_V
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_v,
  input  logic pa,
  input  logic pv,
  output logic sa,
  output logic sv,
  output logic a_noise,
  output logic v_noise
);

  // Either pace can couple into the atrial lead; only a ventricular pace
  // is large enough to blank the ventricular lead.
  logic blank_a;
  logic blank_v;
  assign blank_a = pa | pv;
  assign blank_v = pv;

  sense_channel #(
    .DEB_N    (DEB_N),
    .BLANK_CYC(BLANK_CYC),
    .REFR_LEN (REFR_A)
  ) u_chan_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_a),
    .blank(blank_a),
    .sense(sa),
    .noise(a_noise)
  );

  sense_channel #(
    .DEB_N    (DEB_N),
    .BLANK_CYC(BLANK_CYC),
    .REFR_LEN (REFR_V)
  ) u_chan_v (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_v),
    .blank(blank_v),
    .sense(sv),
    .noise(v_noise)
  );

endmodule
